// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Read-side drain stage for the dual-clock byte FIFO. Lives in the FIFO read
//   clock domain. It pops one byte whenever the FIFO is non-empty and the line
//   is free, and serialises it as a UART frame: start bit, DATA_W data bits LSB
//   first, optional even-parity bit, stop bit. Back-to-back bytes abut with no
//   idle gap, because the next pop is taken on the last cycle of the stop bit.
//
//   Build option: define UART_PARITY_EN to insert an even-parity bit after the
//   data bits (8E1 frames). Left undefined, frames are 8N1 and no parity logic
//   exists.
//
// Ports
//   rclk       in   1       read-domain clock, rising edge
//   rrst_n     in   1       asynchronous active-low reset
//   rempty     in   1       FIFO empty flag; rdata valid when low
//   rdata      in   DATA_W  FIFO head byte (combinational from the FIFO)
//   rreq       out  1       pop strobe, combinational from state/rempty
//   tx         out  1       registered serial line, idle high
//   busy       out  1       registered, high while a frame is in flight
//   byte_done  out  1       registered one-cycle pulse after each stop bit
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rempty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rreq,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [BAUD_W-1:0] baud_q,      baud_d;
  logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0] shift_q,     shift_d;
  logic              tx_q,        tx_d;
  logic              busy_q,      busy_d;
  logic              byte_done_q, byte_done_d;
`ifdef UART_PARITY_EN
  logic              parity_q,    parity_d;
`endif

  logic bit_tick;
  logic pop;

  always_comb begin
    bit_tick = (baud_q == BAUD_LAST);
    // Pop points: idle, or the final cycle of a stop bit so frames abut.
    pop = ~rempty & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_tick));

    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    // Every state change happens on bit_tick (or from IDLE), so wrapping here
    // also clears the counter on every state entry.
    baud_d    = bit_tick ? '0 : baud_q + 1'b1;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop) begin
          state_d = S_START;
          shift_d = rdata;
`ifdef UART_PARITY_EN
          parity_d = ^rdata;
`endif
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          if (pop) begin
            state_d = S_START;
            shift_d = rdata;
`ifdef UART_PARITY_EN
            parity_d = ^rdata;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so tx drops on the cycle
    // right after the pop edge.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d      = (state_d != S_IDLE);
    byte_done_d = (state_q == S_STOP) & bit_tick;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
`ifdef UART_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // The strobe is held off while reset is asserted so the FIFO never loses a
  // byte to a design that is not running.
  assign rreq      = pop & rrst_n;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = 10 + PAR_BITS;
  localparam int FRAME = NBITS * CPB;
  localparam int LOGN  = 8192;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rreq, tx, busy, byte_done;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rreq(rreq), .tx(tx), .busy(busy), .byte_done(byte_done)
  );

  always #5 rclk = ~rclk;

  // Small FIFO model feeding the DUT.
  logic [7:0] fifo_mem [0:63];
  int wr_idx = 0;
  int rd_idx = 0;
  assign rempty = (rd_idx == wr_idx);
  assign rdata  = fifo_mem[rd_idx[5:0]];
  always @(posedge rclk) if (rreq) rd_idx <= rd_idx + 1;

  // Edge counter and per-cycle logs sampled on the falling edge.
  int cyc = 0;
  always @(posedge rclk) cyc <= cyc + 1;
  logic txlog [0:LOGN-1];
  logic busylog [0:LOGN-1];
  int pop_q[$];
  int done_q[$];
  always @(negedge rclk) begin
    if (cyc < LOGN) begin
      txlog[cyc]   = tx;
      busylog[cyc] = busy;
    end
    if (rreq === 1'b1) pop_q.push_back(cyc + 1);  // edge that takes the pop
    if (byte_done === 1'b1) done_q.push_back(cyc);
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // 8N1 line bits, index = bit period
    logic       par;    // even-parity bit
  } vec_t;
  vec_t vecs[8];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_idx[5:0]] = d;
    wr_idx++;
  endtask

  function automatic logic logbit(input int idx);
    if (idx < 0 || idx >= LOGN) return 1'bx;
    return txlog[idx];
  endfunction

  task automatic check_frame(input int n, input vec_t v, input string tag);
    logic e;
    for (int i = 0; i < NBITS; i++) begin
      if (i <= 8) e = v.frame[i];
      else if (PAR_BITS == 1 && i == 9) e = v.par;
      else e = 1'b1;
      check($sformatf("%s_bit%0d", tag, i), {31'd0, logbit(n + CPB*i + CPB/2)}, {31'd0, e});
    end
  endtask

  initial begin
    int p0, d0, c0, ones, n;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[4] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[5] = '{8'h80, 10'b1100000000, 1'b1};
    vecs[6] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[7] = '{8'h03, 10'b1000000110, 1'b0};

    // Reset with the FIFO empty.
    rrst_n = 1'b0;
    wait_cyc(4);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, byte_done}, 32'd0);
    check("rst_rreq", {31'd0, rreq}, 32'd0);
    rrst_n = 1'b1;
    c0 = cyc;
    wait_cyc(100);
    ones = 0;
    for (int k = c0; k < c0 + 100; k++) ones += (txlog[k] === 1'b1 && busylog[k] === 1'b0) ? 1 : 0;
    check("idle_tx_busy", ones, 100);
    check("idle_pops", pop_q.size(), 0);
    check("idle_dones", done_q.size(), 0);

    // Single bytes from the table.
    for (int v = 0; v < 8; v++) begin
      p0 = pop_q.size();
      d0 = done_q.size();
      push(vecs[v].data);
      wait_cyc(FRAME + 10);
      check($sformatf("v%0d_pops", v), pop_q.size() - p0, 1);
      check($sformatf("v%0d_dones", v), done_q.size() - d0, 1);
      if (pop_q.size() > p0) begin
        n = pop_q[p0];
        check_frame(n, vecs[v], $sformatf("v%0d", v));
        check($sformatf("v%0d_busy_on", v), {31'd0, busylog[n]}, 32'd1);
        check($sformatf("v%0d_busy_off", v), {31'd0, busylog[n + FRAME]}, 32'd0);
        check($sformatf("v%0d_idle_before", v), {31'd0, logbit(n - 1)}, 32'd1);
        if (done_q.size() > d0) check($sformatf("v%0d_done_lat", v), done_q[d0] - n, FRAME);
      end
    end

    // Three bytes queued at once stream back to back.
    p0 = pop_q.size();
    d0 = done_q.size();
    push(vecs[1].data); push(vecs[2].data); push(vecs[3].data);
    wait_cyc(3 * FRAME + 20);
    check("str_pops", pop_q.size() - p0, 3);
    check("str_dones", done_q.size() - d0, 3);
    if (pop_q.size() - p0 == 3 && done_q.size() - d0 == 3) begin
      n = pop_q[p0];
      for (int b = 0; b < 3; b++) begin
        check($sformatf("str%0d_spacing", b), pop_q[p0 + b] - n, b * FRAME);
        check($sformatf("str%0d_done_lat", b), done_q[d0 + b] - pop_q[p0 + b], FRAME);
        check_frame(pop_q[p0 + b], vecs[b + 1], $sformatf("str%0d", b));
      end
      check("str_stop_high", {31'd0, logbit(n + FRAME - 1)}, 32'd1);
      check("str_no_gap", {31'd0, logbit(n + FRAME)}, 32'd0);
      ones = 0;
      for (int k = n; k < n + 3 * FRAME; k++) ones += (busylog[k] === 1'b1) ? 1 : 0;
      check("str_busy_cont", ones, 3 * FRAME);
    end

    // Second byte arrives mid-frame: popped on the last stop cycle, no extra pop.
    p0 = pop_q.size();
    push(vecs[0].data);
    wait_cyc(60);
    push(vecs[4].data);
    wait_cyc(2 * FRAME);
    check("mid_pops", pop_q.size() - p0, 2);
    if (pop_q.size() - p0 == 2) begin
      check("mid_spacing", pop_q[p0 + 1] - pop_q[p0], FRAME);
      check_frame(pop_q[p0 + 1], vecs[4], "mid_b2");
    end

    // Reset 50 cycles into a frame; the next queued byte gets a clean frame.
    p0 = pop_q.size();
    push(vecs[5].data);
    push(vecs[6].data);
    wait_cyc(51);
    d0 = done_q.size();
    rrst_n = 1'b0;
    #1;
    check("mrst_tx", {31'd0, tx}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_rreq", {31'd0, rreq}, 32'd0);
    wait_cyc(3);
    check("mrst_rreq_held", {31'd0, rreq}, 32'd0);
    rrst_n = 1'b1;
    wait_cyc(FRAME + 10);
    check("mrst_pops", pop_q.size() - p0, 2);
    check("mrst_dones", done_q.size() - d0, 1);
    if (pop_q.size() - p0 == 2) begin
      check_frame(pop_q[p0 + 1], vecs[6], "mrst_b2");
      if (done_q.size() > d0) check("mrst_done_lat", done_q[d0] - pop_q[p0 + 1], FRAME);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
